// File: rtl/mem_access_pkg.sv
// Shared types and default sizing for the memory access sequencer.
package mem_access_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_PUSH  = 2'b10,
    OP_POP   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_COMPLETE = 2'd2
  } state_e;

  localparam int unsigned DEF_MEM_DEPTH   = 24;
  localparam int unsigned DEF_STACK_DEPTH = 8;
  localparam int unsigned DEF_MAX_STREAK  = 2;

endpackage

// File: rtl/stack_ptr.sv
// Stack pointer with full/empty flags and push/pop index generation.
// MEM_GUARD_EN selects saturating (0..STACK_DEPTH) instead of modulo arithmetic.
module stack_ptr
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned STACK_DEPTH = DEF_STACK_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              dec,
  output logic [ADDR_W-1:0] sp,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-1:0] push_idx,
  output logic [ADDR_W-1:0] pop_idx
);

  localparam logic [ADDR_W-1:0] DEPTH = ADDR_W'(STACK_DEPTH);

  assign full     = (sp == DEPTH);
  assign empty    = (sp == '0);
  assign push_idx = sp;

`ifdef MEM_GUARD_EN
  assign pop_idx = sp - ADDR_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= '0;
    end else if (inc && !full) begin
      sp <= sp + ADDR_W'(1);
    end else if (dec && !empty) begin
      sp <= sp - ADDR_W'(1);
    end
  end
`else
  localparam logic [ADDR_W-1:0] MASK = ADDR_W'(STACK_DEPTH - 1);

  assign pop_idx = (sp - ADDR_W'(1)) & MASK;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= '0;
    end else if (inc) begin
      sp <= (sp + ADDR_W'(1)) & MASK;
    end else if (dec) begin
      sp <= (sp - ADDR_W'(1)) & MASK;
    end
  end
`endif

endmodule

// File: rtl/mem_access_ctrl.sv
// Fetch/data arbiter and IDLE->ISSUE->COMPLETE sequencer for the shared memory.
// Optional MEM_GUARD_EN rejects out-of-range accesses and stack over/underflow.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned MEM_DEPTH   = DEF_MEM_DEPTH,
  parameter int unsigned STACK_DEPTH = DEF_STACK_DEPTH,
  parameter int unsigned MAX_STREAK  = DEF_MAX_STREAK
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic [DATA_W-1:0] f_data,
  input  logic              d_req,
  input  logic [1:0]        d_op,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              m_read,
  output logic              m_write,
  output logic              m_push,
  output logic              m_pop,
  output logic [ADDR_W-1:0] m_addr,
  output logic [ADDR_W-1:0] m_sp,
  output logic [DATA_W-1:0] m_data_in,
  input  logic [DATA_W-1:0] m_out,
  output logic [ADDR_W-1:0] sp,
  output logic              busy
);

  state_e            state;
  op_e               cur_op;
  logic              cur_fetch;
  logic              cur_rej;
  logic [1:0]        streak;
  logic              full, empty;
  logic [ADDR_W-1:0] push_idx, pop_idx;
  logic              sp_inc, sp_dec;
  op_e               req_op;
  logic              fetch_win, data_win;
  logic              f_rej, d_rej;

  // Data wins unless fetch has already waited MAX_STREAK data grants.
  always_comb begin
    req_op    = op_e'(d_op);
    fetch_win = f_req && (!d_req || (streak == 2'(MAX_STREAK)));
    data_win  = d_req && !fetch_win;
  end

`ifdef MEM_GUARD_EN
  assign f_rej = (f_addr >= ADDR_W'(MEM_DEPTH));
  assign d_rej = ((req_op == OP_READ || req_op == OP_WRITE) && (d_addr >= ADDR_W'(MEM_DEPTH)))
              || ((req_op == OP_PUSH) && full)
              || ((req_op == OP_POP) && empty);
`else
  logic guard_unused;
  assign f_rej        = 1'b0;
  assign d_rej        = 1'b0;
  assign guard_unused = ^{full, empty, ADDR_W'(MEM_DEPTH)};
`endif

  assign sp_inc = (state == ST_ISSUE) && !cur_fetch && !cur_rej && (cur_op == OP_PUSH);
  assign sp_dec = (state == ST_ISSUE) && !cur_fetch && !cur_rej && (cur_op == OP_POP);

  stack_ptr #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack_ptr (
    .clk      (clk),
    .rst      (rst),
    .inc      (sp_inc),
    .dec      (sp_dec),
    .sp       (sp),
    .full     (full),
    .empty    (empty),
    .push_idx (push_idx),
    .pop_idx  (pop_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cur_op    <= OP_READ;
      cur_fetch <= 1'b0;
      cur_rej   <= 1'b0;
      streak    <= '0;
      f_ack     <= 1'b0;
      f_data    <= '0;
      d_ack     <= 1'b0;
      d_rdata   <= '0;
      d_err     <= 1'b0;
      m_read    <= 1'b0;
      m_write   <= 1'b0;
      m_push    <= 1'b0;
      m_pop     <= 1'b0;
      m_addr    <= '0;
      m_sp      <= '0;
      m_data_in <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fetch_win) begin
            state     <= ST_ISSUE;
            busy      <= 1'b1;
            cur_fetch <= 1'b1;
            cur_op    <= OP_READ;
            cur_rej   <= f_rej;
            streak    <= '0;
            m_addr    <= f_addr;
            m_read    <= !f_rej;
          end else if (data_win) begin
            state     <= ST_ISSUE;
            busy      <= 1'b1;
            cur_fetch <= 1'b0;
            cur_op    <= req_op;
            cur_rej   <= d_rej;
            streak    <= f_req ? streak + 2'd1 : 2'd0;
            case (req_op)
              OP_READ: begin
                m_addr <= d_addr;
                m_read <= !d_rej;
              end
              OP_WRITE: begin
                m_addr    <= d_addr;
                m_data_in <= d_wdata;
                m_write   <= !d_rej;
              end
              OP_PUSH: begin
                m_sp      <= push_idx;
                m_data_in <= d_wdata;
                m_push    <= !d_rej;
              end
              OP_POP: begin
                m_sp  <= pop_idx;
                m_pop <= !d_rej;
              end
            endcase
          end else begin
            streak <= '0;
          end
        end
        ST_ISSUE: begin
          state   <= ST_COMPLETE;
          m_read  <= 1'b0;
          m_write <= 1'b0;
          m_push  <= 1'b0;
          m_pop   <= 1'b0;
          if (cur_fetch) begin
            f_ack  <= 1'b1;
            f_data <= cur_rej ? '0 : m_out;
          end else begin
            d_ack <= 1'b1;
            d_err <= cur_rej;
            if (!cur_rej && (cur_op == OP_READ || cur_op == OP_POP)) begin
              d_rdata <= m_out;
            end
          end
        end
        ST_COMPLETE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          f_ack <= 1'b0;
          d_ack <= 1'b0;
          d_err <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: scoreboard of expected acks plus
// per-scenario timing/strobe checks. Expectations follow MEM_GUARD_EN if defined.
module tb_mem_access_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       f_req = 1'b0, d_req = 1'b0;
  logic [7:0] f_addr = '0, d_addr = '0, d_wdata = '0;
  logic [1:0] d_op = '0;
  logic       f_ack, d_ack, d_err, busy;
  logic [7:0] f_data, d_rdata;
  logic       m_read, m_write, m_push, m_pop;
  logic [7:0] m_addr, m_sp, m_data_in, m_out, sp;

  typedef struct packed {
    logic       fetch;
    logic       chk;
    logic       err;
    logic [7:0] data;
    logic [7:0] sp;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   vectors = 0;
  int   miscompares = 0;

  logic [7:0] mem [256];
  logic [7:0] stk [8];
  logic [7:0] model_mem [256];
  logic [7:0] model_stk [8];
  int         model_sp = 0;

`ifdef MEM_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  mem_access_ctrl dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_data(f_data),
    .d_req(d_req), .d_op(d_op), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .m_read(m_read), .m_write(m_write), .m_push(m_push), .m_pop(m_pop),
    .m_addr(m_addr), .m_sp(m_sp), .m_data_in(m_data_in), .m_out(m_out),
    .sp(sp), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read during the strobe cycle, write on the edge.
  always_comb m_out = m_read ? mem[m_addr] : (m_pop ? stk[m_sp[2:0]] : 8'h00);

  always @(posedge clk) begin
    if (m_write) mem[m_addr] <= m_data_in;
    if (m_push)  stk[m_sp[2:0]] <= m_data_in;
  end

  // Scoreboard: every ack pops the oldest expected response.
  always @(negedge clk) begin
    if (!rst && (f_ack || d_ack)) begin
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_ack: f_ack=%b d_ack=%b with nothing pending", f_ack, d_ack);
      end else begin
        me = q.pop_front();
        if ({f_ack, d_ack} !== {me.fetch, !me.fetch}) begin
          miscompares++;
          $display("FAIL ack_order: got f_ack=%b d_ack=%b, want fetch=%b", f_ack, d_ack, me.fetch);
        end else if (me.fetch) begin
          vectors++;
          if (f_data !== me.data) begin
            miscompares++;
            $display("FAIL fetch_data: got %h want %h", f_data, me.data);
          end
        end else begin
          vectors++;
          if (d_err !== me.err) begin
            miscompares++;
            $display("FAIL d_err: got %b want %b", d_err, me.err);
          end
          if (me.chk) begin
            vectors++;
            if (d_rdata !== me.data) begin
              miscompares++;
              $display("FAIL d_rdata: got %h want %h", d_rdata, me.data);
            end
          end
        end
        vectors++;
        if (sp !== me.sp) begin
          miscompares++;
          $display("FAIL sp_at_ack: got %0d want %0d", sp, me.sp);
        end
      end
    end
  end

  // Data transaction driver: predicts result, queues it, waits for d_ack.
  task automatic run_data(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] wd,
                          output bit seen, output logic [7:0] st_addr, output logic [7:0] st_sp,
                          output logic [7:0] st_data);
    exp_t e;
    bit   rej, acked;
    int   idx;
    rej = 1'b0;
    if (GUARD) begin
      case (op)
        2'b00, 2'b01: rej = (addr >= 8'd24);
        2'b10:        rej = (model_sp == 8);
        default:      rej = (model_sp == 0);
      endcase
    end
    e = '0;
    e.err = rej;
    if (!rej) begin
      case (op)
        2'b00: begin e.chk = 1'b1; e.data = model_mem[addr]; end
        2'b01: model_mem[addr] = wd;
        2'b10: begin
          model_stk[model_sp % 8] = wd;
          model_sp = GUARD ? model_sp + 1 : (model_sp + 1) % 8;
        end
        default: begin
          idx = (model_sp + 7) % 8;
          e.chk = 1'b1;
          e.data = model_stk[idx];
          model_sp = GUARD ? model_sp - 1 : idx;
        end
      endcase
    end
    e.sp = 8'(model_sp);
    q.push_back(e);
    seen = 1'b0; st_addr = '0; st_sp = '0; st_data = '0; acked = 1'b0;
    d_op = op; d_addr = addr; d_wdata = wd; d_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (m_read || m_write || m_push || m_pop) begin
        seen = 1'b1; st_addr = m_addr; st_sp = m_sp; st_data = m_data_in;
      end
      if (d_ack) begin acked = 1'b1; break; end
    end
    d_req = 1'b0;
    if (!acked) begin
      vectors++; miscompares++;
      void'(q.pop_back());
      $display("FAIL d_ack_timeout: op=%0d got no ack, want ack within 12 cycles", op);
    end
  endtask

  task automatic test_reset();
    vectors++;
    if ({m_read, m_write, m_push, m_pop, f_ack, d_ack, d_err, busy} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 00000000",
               {m_read, m_write, m_push, m_pop, f_ack, d_ack, d_err, busy});
    end
    vectors++;
    if ({f_data, d_rdata, m_addr, m_sp, m_data_in, sp} !== 48'h0) begin
      miscompares++;
      $display("FAIL reset_data: got %h want 0", {f_data, d_rdata, m_addr, m_sp, m_data_in, sp});
    end
  endtask

  task automatic test_fetch_timing();
    exp_t e;
    e = '0; e.fetch = 1'b1; e.chk = 1'b1; e.data = 8'h34; e.sp = 8'(model_sp);
    q.push_back(e);
    f_addr = 8'd3; f_req = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({m_read, busy, f_ack, m_addr} !== {3'b110, 8'd3}) begin
      miscompares++;
      $display("FAIL fetch_n1: got read=%b busy=%b ack=%b addr=%0d want 1 1 0 3", m_read, busy, f_ack, m_addr);
    end
    @(posedge clk); #1;
    vectors++;
    if ({m_read, busy, f_ack, f_data} !== {3'b011, 8'h34}) begin
      miscompares++;
      $display("FAIL fetch_n2: got read=%b busy=%b ack=%b data=%h want 0 1 1 34", m_read, busy, f_ack, f_data);
    end
    f_req = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({busy, f_ack} !== 2'b00) begin
      miscompares++;
      $display("FAIL fetch_n3: got busy=%b ack=%b want 0 0", busy, f_ack);
    end
  endtask

  task automatic test_push_pop();
    bit seen; logic [7:0] a, s, d;
    run_data(2'b10, 8'd0, 8'hAA, seen, a, s, d);
    vectors++;
    if ({seen, s, d} !== {1'b1, 8'd0, 8'hAA}) begin
      miscompares++; $display("FAIL push_aa: got seen=%b m_sp=%0d data=%h want 1 0 aa", seen, s, d);
    end
    run_data(2'b10, 8'd0, 8'hBB, seen, a, s, d);
    vectors++;
    if ({seen, s, d} !== {1'b1, 8'd1, 8'hBB}) begin
      miscompares++; $display("FAIL push_bb: got seen=%b m_sp=%0d data=%h want 1 1 bb", seen, s, d);
    end
    run_data(2'b11, 8'd0, 8'h00, seen, a, s, d);
    vectors++;
    if ({seen, s, d_rdata, sp} !== {1'b1, 8'd1, 8'hBB, 8'd1}) begin
      miscompares++;
      $display("FAIL pop_bb: got seen=%b m_sp=%0d rdata=%h sp=%0d want 1 1 bb 1", seen, s, d_rdata, sp);
    end
  endtask

  task automatic test_reset_mid_write();
    bit seen;
    seen = 1'b0;
    d_op = 2'b01; d_addr = 8'd14; d_wdata = 8'h99; d_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (m_write) begin seen = 1'b1; break; end
    end
    vectors++;
    if (!seen) begin miscompares++; $display("FAIL rst_write_issue: got no m_write want m_write"); end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({m_write, busy} !== 2'b00) begin
      miscompares++; $display("FAIL rst_async: got m_write=%b busy=%b want 0 0", m_write, busy);
    end
    d_req = 1'b0;
    @(posedge clk); #3 rst = 1'b0;
    model_sp = 0;
    @(posedge clk); #1;
    vectors++;
    if ({sp, busy, d_ack} !== {8'd0, 2'b00}) begin
      miscompares++; $display("FAIL rst_after: got sp=%0d busy=%b ack=%b want 0 0 0", sp, busy, d_ack);
    end
  endtask

  task automatic test_stack_bounds();
    bit seen; logic [7:0] a, s, d;
    // Pop on an empty stack: rejected with guard, wraps to index 7 without.
    run_data(2'b11, 8'd0, 8'h00, seen, a, s, d);
    vectors++;
    if (GUARD ? ({seen, sp} !== {1'b0, 8'd0}) : ({seen, s, sp} !== {1'b1, 8'd7, 8'd7})) begin
      miscompares++; $display("FAIL pop_empty: got seen=%b m_sp=%0d sp=%0d guard=%b", seen, s, sp, GUARD);
    end
    run_data(2'b10, 8'd0, 8'h77, seen, a, s, d);
    vectors++;
    if (GUARD ? ({seen, s, sp} !== {1'b1, 8'd0, 8'd1}) : ({seen, s, sp} !== {1'b1, 8'd7, 8'd0})) begin
      miscompares++; $display("FAIL push_wrap: got seen=%b m_sp=%0d sp=%0d guard=%b", seen, s, sp, GUARD);
    end
  endtask

  task automatic test_write_guard();
    bit seen; logic [7:0] a, s, d;
    run_data(2'b01, 8'd30, 8'h66, seen, a, s, d);
    vectors++;
    if (seen !== !GUARD) begin
      miscompares++; $display("FAIL write_30: got strobe=%b want %b", seen, !GUARD);
    end
    run_data(2'b01, 8'd14, 8'h55, seen, a, s, d);
    vectors++;
    if ({seen, a, d} !== {1'b1, 8'd14, 8'h55}) begin
      miscompares++; $display("FAIL write_14: got seen=%b addr=%0d data=%h want 1 14 55", seen, a, d);
    end
    run_data(2'b00, 8'd14, 8'h00, seen, a, s, d);
    run_data(2'b00, 8'd30, 8'h00, seen, a, s, d);
  endtask

  task automatic test_fetch_guard();
    exp_t e;
    bit seen, acked;
    e = '0; e.fetch = 1'b1; e.chk = 1'b1; e.sp = 8'(model_sp);
    e.data = GUARD ? 8'h00 : model_mem[30];
    q.push_back(e);
    seen = 1'b0; acked = 1'b0;
    f_addr = 8'd30; f_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (m_read) seen = 1'b1;
      if (f_ack) begin acked = 1'b1; break; end
    end
    f_req = 1'b0;
    vectors++;
    if ({acked, seen} !== {1'b1, !GUARD}) begin
      miscompares++; $display("FAIL fetch_30: got ack=%b strobe=%b want 1 %b", acked, seen, !GUARD);
    end
    if (!acked) void'(q.pop_back());
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   acks;
    string order;
    order = "DDFDDF";
    for (int i = 0; i < 6; i++) begin
      e = '0; e.sp = 8'(model_sp); e.chk = 1'b1;
      e.fetch = (order[i] == "F");
      e.data = e.fetch ? model_mem[7] : model_mem[5];
      q.push_back(e);
    end
    acks = 0;
    d_op = 2'b00; d_addr = 8'd5; f_addr = 8'd7;
    f_req = 1'b1; d_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (f_ack || d_ack) acks++;
      if (acks == 6) break;
    end
    f_req = 1'b0; d_req = 1'b0;
    vectors++;
    if (acks != 6) begin
      miscompares++; $display("FAIL b2b_count: got %0d acks want 6", acks);
      q.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] <= 8'(i) ^ 8'h5A;
      model_mem[i] = 8'(i) ^ 8'h5A;
    end
    mem[3] <= 8'h34;
    model_mem[3] = 8'h34;
    for (int i = 0; i < 8; i++) begin
      stk[i] <= 8'hC0 + 8'(i);
      model_stk[i] = 8'hC0 + 8'(i);
    end
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_fetch_timing();
    test_push_pop();
    test_reset_mid_write();
    test_stack_bounds();
    test_write_guard();
    test_fetch_guard();
    test_back_to_back();
    vectors++;
    if (q.size() != 0) begin
      miscompares++; $display("FAIL pending_acks: got %0d outstanding want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
